mdb_store_unit: RTL and testbench

//  Write-side counterpart of the register-file data-in path: carries register

---
 rtl/msp_store_pkg.sv | 20 ++
 rtl/store_lane_align.sv | 44 ++++
 rtl/mdb_store_unit.sv | 166 ++++++++++++++++
 tb/tb_mdb_store_unit.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/msp_store_pkg.sv
// Shared definitions for the memory store path.
//   st_state_e : store FSM encoding (idle, write in flight, completion)
//   BE_*       : byte-lane enable codes, bit 0 = low byte, bit 1 = high byte
//   PUSH_DEC   : stack pointer pre-decrement applied by PUSH
package msp_store_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StDone  = 2'd2
  } st_state_e;

  localparam logic [1:0]  BE_NONE  = 2'b00;
  localparam logic [1:0]  BE_LO    = 2'b01;
  localparam logic [1:0]  BE_HI    = 2'b10;
  localparam logic [1:0]  BE_WORD  = 2'b11;

  localparam logic [15:0] PUSH_DEC = 16'd2;

endpackage

// File: rtl/store_lane_align.sv
// Combinational byte-lane steering for a store.
//   bw       in  1 = byte store, 0 = word store
//   addr     in  target address
//   data     in  store data, byte stores use data[7:0]
//   mab      out memory address (word stores forced even)
//   mdb      out data placed on the lane(s) selected by addr[0]
//   be       out lane enables
//   misalign out word store to an odd address
module store_lane_align
  import msp_store_pkg::*;
#(
  parameter int unsigned AW = 16,
  parameter int unsigned DW = 16
) (
  input  logic          bw,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] data,
  output logic [AW-1:0] mab,
  output logic [DW-1:0] mdb,
  output logic [1:0]    be,
  output logic          misalign
);

  always_comb begin
    mab      = addr;
    mdb      = data;
    be       = BE_WORD;
    misalign = 1'b0;
    if (bw) begin
      if (addr[0]) begin
        be  = BE_HI;
        mdb = DW'({data[7:0], 8'h00});
      end else begin
        be  = BE_LO;
        mdb = DW'({8'h00, data[7:0]});
      end
    end else begin
      // Word stores always hit the even address; the odd bit is only reported.
      mab      = {addr[AW-1:1], 1'b0};
      misalign = addr[0];
    end
  end

endmodule

// File: rtl/mdb_store_unit.sv
// Store unit: drives register data onto MAB/MDB for MOV/ALU-to-memory, PUSH
// and CALL writes, with byte-lane steering, mem_ready handshake, PUSH stack
// pointer pre-decrement and a write timeout.
//   clk, rst_n  clock, asynchronous active-low reset
//   st_req      store request (accepted only when idle)
//   st_push     target = sp_in - 2, SP written back on success
//   BW          1 = byte store, 0 = word store
//   st_addr     target address (unused for push)
//   st_data     store data
//   sp_in       current stack pointer
//   mem_ready   memory accepted the write
//   MAB_out     memory address bus
//   MDB_in      memory data bus towards memory
//   MW          memory write strobe
//   byte_en     lane enables
//   sp_out      new stack pointer (valid with sp_we)
//   sp_we       one-cycle SP write enable
//   st_busy     unit not idle
//   st_done     one-cycle completion pulse
//   st_err      completion was a timeout
//   misalign    completion of a word store to an odd address
module mdb_store_unit
  import msp_store_pkg::*;
#(
  parameter int unsigned AW      = 16,
  parameter int unsigned DW      = 16,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          st_req,
  input  logic          st_push,
  input  logic          BW,
  input  logic [AW-1:0] st_addr,
  input  logic [DW-1:0] st_data,
  input  logic [AW-1:0] sp_in,
  input  logic          mem_ready,
  output logic [AW-1:0] MAB_out,
  output logic [DW-1:0] MDB_in,
  output logic          MW,
  output logic [1:0]    byte_en,
  output logic [AW-1:0] sp_out,
  output logic          sp_we,
  output logic          st_busy,
  output logic          st_done,
  output logic          st_err,
  output logic          misalign
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  st_state_e       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;

  logic            push_q;
  logic            mis_q;
  logic [AW-1:0]   tgt_q;
  logic [AW-1:0]   mab_q;
  logic [DW-1:0]   mdb_q;
  logic [1:0]      be_q;

  logic            accept;
  logic [AW-1:0]   tgt;
  logic [AW-1:0]   al_mab;
  logic [DW-1:0]   al_mdb;
  logic [1:0]      al_be;
  logic            al_mis;
  logic [CntW-1:0] cnt_inc;

  assign accept  = (state_q == StIdle) && st_req;
  // Push always pre-decrements by a full word, also for byte pushes.
  assign tgt     = st_push ? (sp_in - AW'(PUSH_DEC)) : st_addr;
  assign cnt_inc = cnt_q + CntW'(1);

  store_lane_align #(
    .AW (AW),
    .DW (DW)
  ) u_align (
    .bw       (BW),
    .addr     (tgt),
    .data     (st_data),
    .mab      (al_mab),
    .mdb      (al_mdb),
    .be       (al_be),
    .misalign (al_mis)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (st_req) begin
          state_d = StIssue;
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end
      StIssue: begin
        if (mem_ready) begin
          state_d = StDone;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == CntW'(TIMEOUT)) begin
            state_d = StDone;
            err_d   = 1'b1;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Bus values are captured at acceptance so they stay stable through the
  // whole write and hold afterwards until the next store.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      push_q <= 1'b0;
      mis_q  <= 1'b0;
      tgt_q  <= '0;
      mab_q  <= '0;
      mdb_q  <= '0;
      be_q   <= BE_NONE;
    end else if (accept) begin
      push_q <= st_push;
      mis_q  <= al_mis;
      tgt_q  <= tgt;
      mab_q  <= al_mab;
      mdb_q  <= al_mdb;
      be_q   <= al_be;
    end
  end

  always_comb begin
    MAB_out  = mab_q;
    MDB_in   = mdb_q;
    MW       = (state_q == StIssue);
    byte_en  = (state_q == StIssue) ? be_q : BE_NONE;
    st_busy  = (state_q != StIdle);
    st_done  = (state_q == StDone);
    st_err   = st_done && err_q;
    misalign = st_done && mis_q;
    sp_we    = st_done && push_q && !err_q;
    sp_out   = sp_we ? tgt_q : '0;
  end

endmodule

// File: tb/tb_mdb_store_unit.sv
module tb_mdb_store_unit;

  localparam int unsigned TO = 15;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        st_req, st_push, BW, mem_ready;
  logic [15:0] st_addr, st_data, sp_in;
  logic [15:0] MAB_out, MDB_in, sp_out;
  logic        MW, sp_we, st_busy, st_done, st_err, misalign;
  logic [1:0]  byte_en;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mdb_store_unit #(
    .AW      (16),
    .DW      (16),
    .TIMEOUT (TO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .st_req    (st_req),
    .st_push   (st_push),
    .BW        (BW),
    .st_addr   (st_addr),
    .st_data   (st_data),
    .sp_in     (sp_in),
    .mem_ready (mem_ready),
    .MAB_out   (MAB_out),
    .MDB_in    (MDB_in),
    .MW        (MW),
    .byte_en   (byte_en),
    .sp_out    (sp_out),
    .sp_we     (sp_we),
    .st_busy   (st_busy),
    .st_done   (st_done),
    .st_err    (st_err),
    .misalign  (misalign)
  );

  typedef struct {
    logic        bw;
    logic        push;
    logic [15:0] addr;
    logic [15:0] data;
    logic [15:0] sp;
    int          delay;   // ISSUE cycles before mem_ready; >= TO means never
    logic [15:0] mab;
    logic [15:0] mdb;
    logic [1:0]  be;
    logic        err;
    logic        mis;
    logic        spwe;
    logic [15:0] spout;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic do_store(input vec_t v, input int idx);
    int mw_cycles;
    int exp_mw;
    exp_mw = v.err ? int'(TO) : v.delay + 1;
    @(negedge clk);
    st_req    = 1'b1;
    st_push   = v.push;
    BW        = v.bw;
    st_addr   = v.addr;
    st_data   = v.data;
    sp_in     = v.sp;
    mem_ready = 1'b0;
    @(negedge clk);
    st_req    = 1'b0;
    mw_cycles = 0;
    for (int k = 0; k < 40; k++) begin
      if (!MW) break;
      mw_cycles++;
      if (k == 0) begin
        check($sformatf("v%0d mab", idx), 32'(MAB_out), 32'(v.mab));
        check($sformatf("v%0d mdb", idx), 32'(MDB_in), 32'(v.mdb));
        check($sformatf("v%0d byte_en", idx), 32'(byte_en), 32'(v.be));
        check($sformatf("v%0d busy", idx), 32'(st_busy), 32'd1);
      end
      mem_ready = (k == v.delay);
      @(negedge clk);
    end
    mem_ready = 1'b0;
    check($sformatf("v%0d mw_cycles", idx), 32'(mw_cycles), 32'(exp_mw));
    check($sformatf("v%0d done", idx), 32'(st_done), 32'd1);
    check($sformatf("v%0d err", idx), 32'(st_err), 32'(v.err));
    check($sformatf("v%0d misalign", idx), 32'(misalign), 32'(v.mis));
    check($sformatf("v%0d sp_we", idx), 32'(sp_we), 32'(v.spwe));
    if (v.spwe) check($sformatf("v%0d sp_out", idx), 32'(sp_out), 32'(v.spout));
    check($sformatf("v%0d done_be", idx), 32'(byte_en), 32'd0);
    @(negedge clk);
    check($sformatf("v%0d idle", idx), 32'({st_busy, st_done, MW}), 32'd0);
    check($sformatf("v%0d mab_hold", idx), 32'(MAB_out), 32'(v.mab));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    //        bw    push  addr      data      sp        dly mab       mdb       be     err   mis   spwe  spout
    vecs[0] = '{1'b0, 1'b0, 16'h0200, 16'hBEEF, 16'h0000, 0,  16'h0200, 16'hBEEF, 2'b11, 1'b0, 1'b0, 1'b0, 16'h0000};
    vecs[1] = '{1'b1, 1'b0, 16'h0201, 16'h12A5, 16'h0000, 0,  16'h0201, 16'hA500, 2'b10, 1'b0, 1'b0, 1'b0, 16'h0000};
    vecs[2] = '{1'b1, 1'b0, 16'h0200, 16'h12A5, 16'h0000, 0,  16'h0200, 16'h00A5, 2'b01, 1'b0, 1'b0, 1'b0, 16'h0000};
    vecs[3] = '{1'b0, 1'b1, 16'h5555, 16'h1234, 16'h0000, 0,  16'hFFFE, 16'h1234, 2'b11, 1'b0, 1'b0, 1'b1, 16'hFFFE};
    vecs[4] = '{1'b0, 1'b0, 16'h0400, 16'h1111, 16'h0000, 99, 16'h0400, 16'h1111, 2'b11, 1'b1, 1'b0, 1'b0, 16'h0000};
    vecs[5] = '{1'b0, 1'b1, 16'h0000, 16'h4321, 16'h0100, 99, 16'h00FE, 16'h4321, 2'b11, 1'b1, 1'b0, 1'b0, 16'h0000};
    vecs[6] = '{1'b0, 1'b0, 16'h0410, 16'h2222, 16'h0000, 3,  16'h0410, 16'h2222, 2'b11, 1'b0, 1'b0, 1'b0, 16'h0000};
    vecs[7] = '{1'b0, 1'b0, 16'h0333, 16'hCAFE, 16'h0000, 0,  16'h0332, 16'hCAFE, 2'b11, 1'b0, 1'b1, 1'b0, 16'h0000};
    vecs[8] = '{1'b1, 1'b1, 16'h0000, 16'h00AB, 16'h0101, 0,  16'h00FF, 16'hAB00, 2'b10, 1'b0, 1'b0, 1'b1, 16'h00FF};
    vecs[9] = '{1'b1, 1'b0, 16'hFFFF, 16'h7777, 16'h0000, 2,  16'hFFFF, 16'h7700, 2'b10, 1'b0, 1'b0, 1'b0, 16'h0000};

    rst_n = 1'b0; st_req = 1'b0; st_push = 1'b0; BW = 1'b0; mem_ready = 1'b0;
    st_addr = '0; st_data = '0; sp_in = '0;
    #3;
    check("reset outs", 32'({MW, byte_en, sp_we, st_busy, st_done, st_err, misalign}), 32'd0);
    check("reset buses", {MAB_out, MDB_in}, 32'd0);
    check("reset sp_out", 32'(sp_out), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) do_store(vecs[i], i);

    // A request arriving mid-write must be dropped, not queued.
    @(negedge clk);
    st_req = 1'b1; st_push = 1'b0; BW = 1'b0; st_addr = 16'h0600; st_data = 16'h5A5A;
    @(negedge clk);
    check("ign mw", 32'(MW), 32'd1);
    st_addr = 16'h0700; st_data = 16'h0001;  // st_req still high during ISSUE
    @(negedge clk);
    check("ign mab", 32'(MAB_out), 32'h0600);
    check("ign mdb", 32'(MDB_in), 32'h5A5A);
    st_req = 1'b0; mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    check("ign done", 32'(st_done), 32'd1);
    @(negedge clk);
    @(negedge clk);
    check("ign no_requeue", 32'({st_busy, MW}), 32'd0);
    check("ign mab_keep", 32'(MAB_out), 32'h0600);

    // Reset in the middle of a push write abandons it silently.
    st_req = 1'b1; st_push = 1'b1; BW = 1'b0; sp_in = 16'h0800; st_data = 16'h9999;
    @(negedge clk);
    st_req = 1'b0;
    check("rst pre mw", 32'(MW), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst async mw", 32'({MW, st_busy, byte_en}), 32'd0);
    mem_ready = 1'b1;
    @(negedge clk);
    check("rst no done", 32'({st_done, sp_we, st_err}), 32'd0);
    @(negedge clk);
    check("rst still idle", 32'({st_done, sp_we, MW}), 32'd0);
    mem_ready = 1'b0;
    rst_n = 1'b1;
    do_store(vecs[3], 10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
